// File: rtl/adau1761_reg_sequencer_if.sv
// rtl/adau1761_reg_sequencer_if.sv - request/response bus between control fabric and the register sequencer
//
// Request side : req_valid/req_ready handshake carrying {req_rnw, req_addr, req_wdata}
// Response side: rsp_valid single-cycle pulse (no backpressure) carrying
//                {rsp_rnw, rsp_addr, rsp_data, rsp_error}
// master modport: control fabric; slave modport: adau1761_reg_sequencer

interface adau1761_reg_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_rnw;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;

  logic        rsp_valid;
  logic        rsp_rnw;
  logic [15:0] rsp_addr;
  logic [7:0]  rsp_data;
  logic        rsp_error;

  modport master (
    output req_valid, req_rnw, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rnw, rsp_addr, rsp_data, rsp_error
  );

  modport slave (
    input  req_valid, req_rnw, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rnw, rsp_addr, rsp_data, rsp_error
  );
endinterface

// File: rtl/adau1761_reg_sequencer.sv
// rtl/adau1761_reg_sequencer.sv - request FIFO and command sequencer in front of the ADAU1761 SPI configurator
//
// Optional feature macro: ADAU_SEQ_AUTO_INIT_EN (fire cfg_init after reset, hold requests until done)
//
// Ports:
//   clk, resetn          system clock (shared with configurator), synchronous active-low reset
//   bus (slave)          request handshake in, response pulse out (see adau1761_reg_sequencer_if)
//   cfg_address          configurator register address (holds between commands)
//   cfg_write_value      configurator write data (holds between commands)
//   cfg_write/read/init  registered one-cycle strobes to the configurator
//   cfg_cs               configurator chip-select, low while a transfer is running
//   cfg_read_value       configurator read result, low byte returned on reads
//   init_done            codec initialised; no request is issued before this is high
//   busy                 sequencer is anywhere other than IDLE
//   fifo_level           request FIFO occupancy

module adau1761_reg_sequencer #(
  parameter int FIFO_DEPTH = 8,   // power of two, >= 2
  parameter int IDLE_GAP   = 8,   // >= 4
  parameter int TIMEOUT    = 64   // >= 2
) (
  input  logic                          clk,
  input  logic                          resetn,
  adau1761_reg_sequencer_if.slave       bus,
  output logic [15:0]                   cfg_address,
  output logic [7:0]                    cfg_write_value,
  output logic                          cfg_write,
  output logic                          cfg_read,
  output logic                          cfg_init,
  input  logic                          cfg_cs,
  input  logic [39:0]                   cfg_read_value,
  output logic                          init_done,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam int GW = $clog2(IDLE_GAP) + 1;

  localparam logic [AW:0]   LEVEL_FULL = (AW + 1)'(FIFO_DEPTH);
  // Both counters leave their state on the edge where they would reach the
  // limit, so the error response lands TIMEOUT cycles after the strobe and
  // completion lands IDLE_GAP cycles after the final cfg_cs rise.
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 2);
  localparam logic [GW-1:0] GAP_LAST   = GW'(IDLE_GAP - 1);

  typedef enum logic [2:0] {
`ifdef ADAU_SEQ_AUTO_INIT_EN
    S_INIT_ISSUE,
    S_INIT_WAIT_LOW,
    S_INIT_GAP,
`endif
    S_IDLE,
    S_ISSUE,
    S_WAIT_LOW,
    S_WAIT_GAP,
    S_RESPOND
  } state_t;

`ifdef ADAU_SEQ_AUTO_INIT_EN
  localparam state_t S_RESET = S_INIT_ISSUE;
`else
  localparam state_t S_RESET = S_IDLE;
`endif

  state_t          state, state_d;
  logic [TW-1:0]   tmo_cnt, tmo_d;
  logic [GW-1:0]   gap_cnt, gap_d;
  logic            err_flag, err_d;
  logic            cmd_rnw;
  logic            rsp_load;

  // ---------------------------------------------------------------------
  // Request FIFO: entry = {rnw, addr[15:0], wdata[7:0]}
  // ---------------------------------------------------------------------
  logic [24:0]     fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [24:0]     head;
  logic            push, pop;

  assign head          = fifo_mem[rd_ptr];
  // Ready comes from the registered level only, so a pop in the same cycle
  // cannot re-open a full FIFO.
  assign bus.req_ready = (fifo_level < LEVEL_FULL);
  assign push          = bus.req_valid && bus.req_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {bus.req_rnw, bus.req_addr, bus.req_wdata};
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Sequencer FSM, next-state / control
  // ---------------------------------------------------------------------
`ifdef ADAU_SEQ_AUTO_INIT_EN
  logic init_done_d;
  logic init_stb;
`endif

  always_comb begin
    state_d  = state;
    tmo_d    = tmo_cnt;
    gap_d    = gap_cnt;
    err_d    = err_flag;
    pop      = 1'b0;
    rsp_load = 1'b0;
`ifdef ADAU_SEQ_AUTO_INIT_EN
    init_done_d = init_done;
    init_stb    = 1'b0;
`endif
    case (state)
`ifdef ADAU_SEQ_AUTO_INIT_EN
      S_INIT_ISSUE: begin
        init_stb = 1'b1;
        tmo_d    = '0;
        state_d  = S_INIT_WAIT_LOW;
      end
      S_INIT_WAIT_LOW: begin
        if (!cfg_cs) begin
          gap_d   = '0;
          state_d = S_INIT_GAP;
        end else if (tmo_cnt == TMO_LAST) begin
          // An init timeout has no response to carry an error, so the flag
          // is left clear rather than leaking into the first request.
          init_done_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          tmo_d = tmo_cnt + 1'b1;
        end
      end
      S_INIT_GAP: begin
        // Short high gaps between the init writes clear the counter, so
        // the whole init burst reads as one operation.
        if (!cfg_cs) begin
          gap_d = '0;
        end else if (gap_cnt == GAP_LAST) begin
          init_done_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          gap_d = gap_cnt + 1'b1;
        end
      end
`endif
      S_IDLE: begin
        if (init_done && (fifo_level != '0)) begin
          pop     = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tmo_d   = '0;
        state_d = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        if (!cfg_cs) begin
          gap_d   = '0;
          state_d = S_WAIT_GAP;
        end else if (tmo_cnt == TMO_LAST) begin
          err_d    = 1'b1;
          rsp_load = 1'b1;
          state_d  = S_RESPOND;
        end else begin
          tmo_d = tmo_cnt + 1'b1;
        end
      end
      S_WAIT_GAP: begin
        if (!cfg_cs) begin
          gap_d = '0;
        end else if (gap_cnt == GAP_LAST) begin
          rsp_load = 1'b1;
          state_d  = S_RESPOND;
        end else begin
          gap_d = gap_cnt + 1'b1;
        end
      end
      S_RESPOND: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state           <= S_RESET;
      tmo_cnt         <= '0;
      gap_cnt         <= '0;
      err_flag        <= 1'b0;
      cmd_rnw         <= 1'b0;
      cfg_address     <= '0;
      cfg_write_value <= '0;
      cfg_write       <= 1'b0;
      cfg_read        <= 1'b0;
      busy            <= 1'b0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rnw     <= 1'b0;
      bus.rsp_addr    <= '0;
      bus.rsp_data    <= '0;
      bus.rsp_error   <= 1'b0;
    end else begin
      state    <= state_d;
      tmo_cnt  <= tmo_d;
      gap_cnt  <= gap_d;
      err_flag <= err_d;
      busy     <= (state_d != S_IDLE);

      // Strobes and command fields are loaded on the pop edge so they are
      // visible during the ISSUE cycle; cfg_address doubles as the held
      // command address for the response echo.
      cfg_write <= pop && !head[24];
      cfg_read  <= pop &&  head[24];
      if (pop) begin
        cmd_rnw         <= head[24];
        cfg_address     <= head[23:8];
        cfg_write_value <= head[7:0];
      end

      bus.rsp_valid <= rsp_load;
      if (rsp_load) begin
        bus.rsp_rnw   <= cmd_rnw;
        bus.rsp_addr  <= cfg_address;
        bus.rsp_data  <= cmd_rnw ? cfg_read_value[7:0] : 8'h00;
        bus.rsp_error <= err_d;
      end
    end
  end

`ifdef ADAU_SEQ_AUTO_INIT_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cfg_init  <= 1'b0;
      init_done <= 1'b0;
    end else begin
      cfg_init  <= init_stb;
      init_done <= init_done_d;
    end
  end
`else
  assign cfg_init = 1'b0;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      init_done <= 1'b0;
    end else begin
      init_done <= 1'b1;
    end
  end
`endif

  // Only the low byte of the configurator result is returned.
  logic unused_read_bits;
  assign unused_read_bits = ^cfg_read_value[39:8];

endmodule

// File: tb/tb_adau1761_reg_sequencer.sv
// tb/tb_adau1761_reg_sequencer.sv - directed scoreboard bench for adau1761_reg_sequencer

module tb_adau1761_reg_sequencer;

  localparam int FIFO_DEPTH = 8;
  localparam int IDLE_GAP   = 8;
  localparam int TIMEOUT    = 64;
  localparam int XFER       = 34;
  localparam int BOUND      = 8000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] cfg_address;
  logic [7:0]  cfg_write_value;
  logic        cfg_write, cfg_read, cfg_init;
  logic        cfg_cs = 1'b1;
  logic [39:0] cfg_read_value = '0;
  logic        init_done, busy;
  logic [3:0]  fifo_level;

  adau1761_reg_sequencer_if bus();

  adau1761_reg_sequencer #(
    .FIFO_DEPTH(FIFO_DEPTH), .IDLE_GAP(IDLE_GAP), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus),
    .cfg_address(cfg_address), .cfg_write_value(cfg_write_value),
    .cfg_write(cfg_write), .cfg_read(cfg_read), .cfg_init(cfg_init),
    .cfg_cs(cfg_cs), .cfg_read_value(cfg_read_value),
    .init_done(init_done), .busy(busy), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        rnw;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        err;
  } item_t;

  item_t cmd_q[$];
  item_t rsp_q[$];

  int errors = 0;
  int checks = 0;
  int stuck_count = 0;
  int last_rise_cyc = 0;
  int rise_count = 0;
  int last_strobe_cyc = 0;
  int last_push_cyc = 0;
  int init_pulses = 0;
  int rsp_count = 0;
  int peak_level = 0;
  logic prev_stb = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Configurator model: after a strobe, cs drops for XFER cycles per transfer.
  task automatic run_xfers(input int k);
    for (int i = 0; i < k; i++) begin
      if (i == 0) repeat (2) @(negedge clk);
      else repeat ($urandom_range(1, 3)) @(negedge clk);
      cfg_cs = 1'b0;
      repeat (XFER) @(negedge clk);
      cfg_cs = 1'b1;
      last_rise_cyc = cyc;
      rise_count++;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (cfg_init) run_xfers(21);
        else if (cfg_write || cfg_read) begin
          if (stuck_count > 0) stuck_count--;
          else run_xfers(1);
        end
      end
    end
  end

  // Monitor: strobe and response scoreboards.
  initial begin
    item_t e;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        prev_stb = 1'b0;
      end else begin
        if (cfg_init) init_pulses++;
        if (int'(fifo_level) > peak_level) peak_level = int'(fifo_level);
        if (cfg_write || cfg_read) begin
          check("strobe_one_cycle", prev_stb, 1'b0);
          check("strobe_exclusive", cfg_write && cfg_read, 1'b0);
          check("strobe_expected", cmd_q.size() != 0, 1'b1);
          if (cmd_q.size() != 0) begin
            e = cmd_q.pop_front();
            check("strobe_rnw", cfg_read, e.rnw);
            check("cfg_address", cfg_address, e.addr);
            if (!e.rnw) check("cfg_write_value", cfg_write_value, e.data);
          end
          last_strobe_cyc = cyc;
        end
        prev_stb = cfg_write || cfg_read;
        if (bus.rsp_valid) begin
          rsp_count++;
          check("rsp_expected", rsp_q.size() != 0, 1'b1);
          if (rsp_q.size() != 0) begin
            e = rsp_q.pop_front();
            check("rsp_rnw", bus.rsp_rnw, e.rnw);
            check("rsp_addr", bus.rsp_addr, e.addr);
            check("rsp_data", bus.rsp_data, e.data);
            check("rsp_error", bus.rsp_error, e.err);
            if (e.err) check("timeout_latency", cyc - last_strobe_cyc, TIMEOUT);
            else check("gap_latency", cyc - last_rise_cyc, IDLE_GAP);
          end
        end
      end
    end
  end

  task automatic push_req(input logic rnw, input logic [15:0] addr, input logic [7:0] wdata, input logic err);
    item_t r;
    int n;
    bus.req_valid = 1'b1;
    bus.req_rnw   = rnw;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    n = 0;
    while (!bus.req_ready && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check("push_accept", bus.req_ready, 1'b1);
    r.rnw = rnw; r.addr = addr; r.data = wdata; r.err = 1'b0;
    cmd_q.push_back(r);
    r.data = rnw ? cfg_read_value[7:0] : 8'h00;
    r.err  = err;
    rsp_q.push_back(r);
    last_push_cyc = cyc;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((rsp_q.size() != 0 || busy) && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check(tag, rsp_q.size(), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_strobes_flags"},
          {cfg_write, cfg_read, cfg_init, busy, init_done, bus.rsp_valid, bus.rsp_rnw, bus.rsp_error}, 8'h00);
    check({tag, "_ready_level"}, {bus.req_ready, fifo_level}, 5'b1_0000);
    check({tag, "_cfg_bus"}, {cfg_address, cfg_write_value}, 24'h0);
    check({tag, "_rsp_bus"}, {bus.rsp_addr, bus.rsp_data}, 24'h0);
  endtask

  task automatic after_release(input int rc0, input int rsp0);
`ifdef ADAU_SEQ_AUTO_INIT_EN
    int n = 0;
    while (!init_done && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check("init_done_rise", init_done, 1'b1);
    check("init_latency", cyc - last_rise_cyc, IDLE_GAP);
    check("init_transfers", rise_count - rc0, 21);
    check("init_no_rsp", rsp_count - rsp0, 0);
`else
    @(negedge clk);
    check("init_done_after_reset", init_done, 1'b1);
    check("no_init_activity", rise_count - rc0, 0);
    check("no_rsp_after_reset", rsp_count - rsp0, 0);
`endif
  endtask

  initial begin
    int rc0;
    int rsp0;
    bus.req_valid = 1'b0;
    bus.req_rnw   = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    repeat (3) @(negedge clk);
    check_reset_values("reset");
    resetn = 1'b1;
    after_release(0, 0);

    // Single write, also checks push->strobe latency.
    push_req(1'b0, 16'h4015, 8'h01, 1'b0);
    wait_drain("write_drain");
    check("strobe_latency", last_strobe_cyc - last_push_cyc, 2);

    // Single read.
    cfg_read_value = 40'h12_3456_7801;
    push_req(1'b1, 16'h4000, 8'h00, 1'b0);
    wait_drain("read_drain");

    // Burst: 9 back-to-back, the first is popped at once, 8 fill the FIFO.
    cfg_read_value = 40'hFF_FFFF_FF5A;
    for (int i = 0; i < 9; i++) push_req(i[0], 16'h4020 + 16'(i * 3), 8'(i * 17), 1'b0);
    check("burst_full_level", fifo_level, 4'd8);
    check("burst_full_ready", bus.req_ready, 1'b0);
    push_req(1'b1, 16'h40AA, 8'h00, 1'b0);
    wait_drain("burst_drain");
    check("peak_level", peak_level, FIFO_DEPTH);

    // Timeout then a normal request.
    stuck_count = 1;
    push_req(1'b0, 16'h4017, 8'hA5, 1'b1);
    cfg_read_value = 40'h00_0000_003C;
    push_req(1'b1, 16'h4018, 8'h00, 1'b0);
    wait_drain("timeout_drain");

    // Reset mid WAIT_GAP with 3 requests queued.
    rc0 = rise_count;
    for (int i = 0; i < 4; i++) push_req(1'b0, 16'h4030 + 16'(i), 8'(8'h80 + i), 1'b0);
    begin
      int n = 0;
      while (rise_count == rc0 && n < BOUND) begin
        @(negedge clk);
        n++;
      end
    end
    check("reset_test_rise", rise_count - rc0, 1);
    repeat (2) @(negedge clk);
    check("queued_before_reset", fifo_level, 4'd3);
    resetn = 1'b0;
    cmd_q.delete();
    rsp_q.delete();
    @(negedge clk);
    check_reset_values("mid_reset");
    rc0 = rise_count;
    rsp0 = rsp_count;
    resetn = 1'b1;
    after_release(rc0, rsp0);
    repeat (60) @(negedge clk);
    check("no_stale_rsp", rsp_count - rsp0, 0);

    // Recovery request.
    cfg_read_value = 40'h00_0000_0077;
    push_req(1'b1, 16'h40F0, 8'h00, 1'b0);
    wait_drain("recovery_drain");

`ifdef ADAU_SEQ_AUTO_INIT_EN
    check("init_pulses", init_pulses, 2);
`else
    check("init_pulses", init_pulses, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
